// File: rtl/uart_reg_master.sv
// rtl/uart_reg_master.sv - register-port initiator bridging TX/RX byte streams to the UART peripheral
// Optional: define UART_REG_MASTER_STATS_EN to add the tx_count/rx_count outputs.
module uart_reg_master #(
    parameter int         FIFO_DEPTH = 4,
    parameter int         TIMEOUT    = 65535,
    parameter logic [7:0] CTRL_INIT  = 8'h11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  s_tx_data,
    input  logic        s_tx_valid,
    output logic        s_tx_ready,
    output logic [7:0]  m_rx_data,
    output logic        m_rx_valid,
    input  logic        m_rx_ready,
    output logic        uart_wren,
    output logic [2:0]  uart_addr,
    output logic [7:0]  uart_wdata,
    input  logic [7:0]  uart_rdata,
    output logic        rx_overflow,
    output logic        tx_timeout
`ifdef UART_REG_MASTER_STATS_EN
    ,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
    localparam logic [2:0] ADDR_CTRL = 3'd0;
    localparam logic [2:0] ADDR_TXD  = 3'd1;
    localparam logic [2:0] ADDR_RXD  = 3'd2;
    localparam logic [7:0] CTRL_GO   = CTRL_INIT | 8'h04;

    typedef enum logic [3:0] {
        ST_INIT, ST_POLL, ST_EVAL, ST_RX_READ, ST_RX_CAP,
        ST_TX_DATA, ST_TX_GO, ST_TX_WAIT, ST_TX_DROP
    } state_t;

    state_t        state_q;
    logic          uart_wren_q;
    logic [2:0]    uart_addr_q;
    logic [7:0]    uart_wdata_q;
    logic          s_tx_ready_q;
    logic          rx_valid_q;
    logic          rx_overflow_q;
    logic          tx_timeout_q;
    logic [CW-1:0] cnt_q;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_push  = (state_q == ST_RX_CAP) && !fifo_full;
    assign fifo_pop   = !fifo_empty && m_rx_ready;
    assign wr_ptr_d   = wr_ptr_q + PW'(fifo_push);
    assign rd_ptr_d   = rd_ptr_q + PW'(fifo_pop);

    always_ff @(posedge clock) begin
        if (fifo_push) fifo_mem[wr_ptr_q[AW-1:0]] <= uart_rdata;
    end

    // Every state's bus action is registered here, so it appears on the port in the following cycle;
    // uart_rdata is therefore valid at the edge after a read has been presented.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_INIT;
            uart_wren_q   <= 1'b0;
            uart_addr_q   <= ADDR_CTRL;
            uart_wdata_q  <= 8'h00;
            s_tx_ready_q  <= 1'b0;
            rx_valid_q    <= 1'b0;
            rx_overflow_q <= 1'b0;
            tx_timeout_q  <= 1'b0;
            cnt_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            uart_wren_q  <= 1'b0;
            uart_addr_q  <= ADDR_CTRL;
            s_tx_ready_q <= 1'b0;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            case (state_q)
                ST_INIT: begin
                    uart_wren_q  <= 1'b1;
                    uart_wdata_q <= CTRL_INIT;
                    state_q      <= ST_POLL;
                end
                ST_POLL: state_q <= ST_EVAL;
                ST_EVAL: begin
                    rx_valid_q <= uart_rdata[6];
                    if (uart_rdata[6] && !rx_valid_q) begin
                        state_q <= ST_RX_READ;
                    end else if (s_tx_valid && uart_rdata[1]) begin
                        s_tx_ready_q <= 1'b1;
                        state_q      <= ST_TX_DATA;
                    end else begin
                        state_q <= ST_POLL;
                    end
                end
                ST_RX_READ: begin
                    uart_addr_q <= ADDR_RXD;
                    state_q     <= ST_RX_CAP;
                end
                ST_RX_CAP: begin
                    if (fifo_full) rx_overflow_q <= 1'b1;
                    state_q <= ST_POLL;
                end
                ST_TX_DATA: begin
                    uart_wren_q  <= 1'b1;
                    uart_addr_q  <= ADDR_TXD;
                    uart_wdata_q <= s_tx_data;
                    state_q      <= ST_TX_GO;
                end
                ST_TX_GO: begin
                    uart_wren_q  <= 1'b1;
                    uart_wdata_q <= CTRL_GO;
                    cnt_q        <= '0;
                    state_q      <= ST_TX_WAIT;
                end
                ST_TX_WAIT: begin
                    // The first cycle here still shows the TX_VALID write, so only sample on read cycles.
                    if (!uart_wren_q) rx_valid_q <= uart_rdata[6];
                    if (!uart_wren_q && !uart_rdata[1]) begin
                        state_q <= ST_TX_DROP;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        tx_timeout_q <= 1'b1;
                        state_q      <= ST_TX_DROP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_TX_DROP: begin
                    uart_wren_q  <= 1'b1;
                    uart_wdata_q <= CTRL_INIT;
                    state_q      <= ST_POLL;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

`ifdef UART_REG_MASTER_STATS_EN
    logic [15:0] tx_count_q, rx_count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_count_q <= 16'h0000;
            rx_count_q <= 16'h0000;
        end else begin
            if (state_q == ST_TX_DATA) tx_count_q <= tx_count_q + 16'd1;
            if (fifo_push)             rx_count_q <= rx_count_q + 16'd1;
        end
    end

    assign tx_count = tx_count_q;
    assign rx_count = rx_count_q;
`endif

    assign s_tx_ready  = s_tx_ready_q;
    assign m_rx_data   = fifo_mem[rd_ptr_q[AW-1:0]];
    assign m_rx_valid  = !fifo_empty;
    assign uart_wren   = uart_wren_q;
    assign uart_addr   = uart_addr_q;
    assign uart_wdata  = uart_wdata_q;
    assign rx_overflow = rx_overflow_q;
    assign tx_timeout  = tx_timeout_q;

endmodule

// File: tb/tb_uart_reg_master.sv
// tb/tb_uart_reg_master.sv - scoreboard bench for uart_reg_master against a behavioural register-port model
`timescale 1ns/1ps
module tb_uart_reg_master;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  s_tx_data = 8'h00;
    logic        s_tx_valid = 1'b0;
    logic        s_tx_ready;
    logic [7:0]  m_rx_data;
    logic        m_rx_valid;
    logic        m_rx_ready = 1'b0;
    logic        uart_wren;
    logic [2:0]  uart_addr;
    logic [7:0]  uart_wdata;
    logic [7:0]  uart_rdata;
    logic        rx_overflow;
    logic        tx_timeout;
`ifdef UART_REG_MASTER_STATS_EN
    logic [15:0] tx_count, rx_count;
`endif

    logic        tx_ready_m = 1'b1;
    logic        rx_valid_m = 1'b0;
    logic [7:0]  rxd_m = 8'h00;

    int checks = 0;
    int passes = 0;
    int nwr = 0;
    int nrd2 = 0;
    int nready = 0;
    logic [10:0] obs_wr[$];
    logic [10:0] exp_wr[$];
    logic [7:0]  obs_rx[$];
    logic [7:0]  exp_rx[$];
    logic [7:0]  ev_q[$];

    always #5 clock = ~clock;

    assign uart_rdata = (uart_addr == 3'd0) ? {1'b0, rx_valid_m, 4'b0100, tx_ready_m, 1'b1} :
                        (uart_addr == 3'd2) ? rxd_m : 8'h00;

    uart_reg_master #(.FIFO_DEPTH(4), .TIMEOUT(16), .CTRL_INIT(8'h11)) dut (
        .clock(clock), .reset(reset),
        .s_tx_data(s_tx_data), .s_tx_valid(s_tx_valid), .s_tx_ready(s_tx_ready),
        .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid), .m_rx_ready(m_rx_ready),
        .uart_wren(uart_wren), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
        .uart_rdata(uart_rdata), .rx_overflow(rx_overflow), .tx_timeout(tx_timeout)
`ifdef UART_REG_MASTER_STATS_EN
        , .tx_count(tx_count), .rx_count(rx_count)
`endif
    );

    always @(negedge clock) begin
        if (uart_wren) begin
            obs_wr.push_back({uart_addr, uart_wdata});
            nwr++;
            if (uart_addr == 3'd1) ev_q.push_back(8'h54);
        end else if (uart_addr == 3'd2) begin
            nrd2++;
            ev_q.push_back(8'h52);
        end
        if (s_tx_ready) nready++;
        if (m_rx_valid && m_rx_ready) obs_rx.push_back(m_rx_data);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic offer_tx(input logic [7:0] d, input bit accept, output bit ok);
        int n0, k;
        ok = 1'b1;
        n0 = nwr;
        s_tx_data = d;
        s_tx_valid = 1'b1;
        k = 0;
        while (s_tx_ready !== 1'b1 && k < 200) begin step(1); k++; end
        if (s_tx_ready !== 1'b1) ok = 1'b0;
        @(posedge clock); #1;
        s_tx_valid = 1'b0;
        k = 0;
        while (nwr < n0 + 2 && k < 50) begin step(1); k++; end
        if (nwr < n0 + 2) ok = 1'b0;
        if (accept) begin
            repeat (3) @(posedge clock);
            #1;
            tx_ready_m = 1'b0;
        end
        k = 0;
        while (nwr < n0 + 3 && k < 100) begin step(1); k++; end
        if (nwr < n0 + 3) ok = 1'b0;
        tx_ready_m = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        step(3);
        checks++; if (uart_wren !== 1'b0) $display("FAIL reset_wren got %b want 0", uart_wren); else passes++;
        checks++; if (uart_addr !== 3'd0) $display("FAIL reset_addr got %0d want 0", uart_addr); else passes++;
        checks++; if (uart_wdata !== 8'h00) $display("FAIL reset_wdata got %h want 00", uart_wdata); else passes++;
        checks++; if (s_tx_ready !== 1'b0) $display("FAIL reset_tx_ready got %b want 0", s_tx_ready); else passes++;
        checks++; if (m_rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b want 0", m_rx_valid); else passes++;
        checks++; if (rx_overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", rx_overflow); else passes++;
        checks++; if (tx_timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", tx_timeout); else passes++;
`ifdef UART_REG_MASTER_STATS_EN
        checks++; if (tx_count !== 16'h0) $display("FAIL reset_tx_count got %0d want 0", tx_count); else passes++;
        checks++; if (rx_count !== 16'h0) $display("FAIL reset_rx_count got %0d want 0", rx_count); else passes++;
`endif
        reset = 1'b1;
        step(1);
        checks++; if ({uart_wren, uart_addr, uart_wdata} !== {1'b1, 3'd0, 8'h11})
            $display("FAIL init_write got wren=%b addr=%0d data=%h want 1/0/11", uart_wren, uart_addr, uart_wdata);
        else passes++;
        step(1);
        checks++; if ({uart_wren, uart_addr} !== {1'b0, 3'd0})
            $display("FAIL poll_read got wren=%b addr=%0d want 0/0", uart_wren, uart_addr);
        else passes++;
        step(6);
        checks++; if (obs_wr.size() != 1) $display("FAIL init_write_count got %0d want 1", obs_wr.size()); else passes++;
        obs_wr.delete();
    endtask

    task automatic test_tx;
        bit ok;
        int r0;
        logic [10:0] e, o;
        r0 = nready;
        exp_wr.push_back({3'd1, 8'hA5});
        exp_wr.push_back({3'd0, 8'h15});
        exp_wr.push_back({3'd0, 8'h11});
        offer_tx(8'hA5, 1'b1, ok);
        step(2);
        checks++; if (ok !== 1'b1) $display("FAIL tx_handshake got %b want 1", ok); else passes++;
        checks++; if (nready - r0 != 1) $display("FAIL tx_ready_pulses got %0d want 1", nready - r0); else passes++;
        checks++; if (tx_timeout !== 1'b0) $display("FAIL tx_timeout_flag got %b want 0", tx_timeout); else passes++;
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) $display("FAIL tx_write got none want %h", e);
            else begin
                o = obs_wr.pop_front();
                if (o !== e) $display("FAIL tx_write got %h want %h", o, e); else passes++;
            end
        end
        checks++; if (obs_wr.size() != 0) $display("FAIL tx_extra_writes got %0d want 0", obs_wr.size()); else passes++;
        obs_wr.delete();
    endtask

    task automatic test_rx_single;
        int d0;
        logic [7:0] e, o;
        d0 = nrd2;
        m_rx_ready = 1'b1;
        rxd_m = 8'h3C;
        rx_valid_m = 1'b1;
        exp_rx.push_back(8'h3C);
        step(200);
        rx_valid_m = 1'b0;
        step(10);
        checks++; if (nrd2 - d0 != 1) $display("FAIL rx_single_reads got %0d want 1", nrd2 - d0); else passes++;
        checks++; if (obs_rx.size() != 1) $display("FAIL rx_single_pops got %0d want 1", obs_rx.size()); else passes++;
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            checks++;
            if (obs_rx.size() == 0) $display("FAIL rx_single_data got none want %h", e);
            else begin
                o = obs_rx.pop_front();
                if (o !== e) $display("FAIL rx_single_data got %h want %h", o, e); else passes++;
            end
        end
        checks++; if (m_rx_valid !== 1'b0) $display("FAIL rx_single_empty got %b want 0", m_rx_valid); else passes++;
        obs_rx.delete();
    endtask

    task automatic test_rx_overflow;
        int d0;
        logic [7:0] e, o;
        m_rx_ready = 1'b0;
        d0 = nrd2;
        for (int i = 1; i <= 5; i++) begin
            rxd_m = 8'(i);
            rx_valid_m = 1'b1;
            step(10);
            rx_valid_m = 1'b0;
            step(10);
            if (i <= 4) exp_rx.push_back(8'(i));
            if (i == 4) begin
                checks++; if (rx_overflow !== 1'b0) $display("FAIL ovf_early got %b want 0", rx_overflow); else passes++;
            end
        end
        checks++; if (rx_overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", rx_overflow); else passes++;
        checks++; if (nrd2 - d0 != 5) $display("FAIL ovf_reads got %0d want 5", nrd2 - d0); else passes++;
        checks++; if ({m_rx_valid, m_rx_data} !== {1'b1, 8'h01})
            $display("FAIL ovf_head got valid=%b data=%h want 1/01", m_rx_valid, m_rx_data);
        else passes++;
        @(posedge clock); #1;
        m_rx_ready = 1'b1;
        step(10);
        @(posedge clock); #1;
        m_rx_ready = 1'b0;
        step(1);
        checks++; if (m_rx_valid !== 1'b0) $display("FAIL ovf_drained got %b want 0", m_rx_valid); else passes++;
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            checks++;
            if (obs_rx.size() == 0) $display("FAIL ovf_data got none want %h", e);
            else begin
                o = obs_rx.pop_front();
                if (o !== e) $display("FAIL ovf_data got %h want %h", o, e); else passes++;
            end
        end
        checks++; if (obs_rx.size() != 0) $display("FAIL ovf_extra got %0d want 0", obs_rx.size()); else passes++;
        obs_rx.delete();
    endtask

    task automatic test_timeout;
        int n0, k;
        bit ok;
        logic [10:0] e, o;
        n0 = nwr;
        exp_wr.push_back({3'd1, 8'hB7});
        exp_wr.push_back({3'd0, 8'h15});
        exp_wr.push_back({3'd0, 8'h11});
        s_tx_data = 8'hB7;
        s_tx_valid = 1'b1;
        k = 0;
        while (s_tx_ready !== 1'b1 && k < 200) begin step(1); k++; end
        checks++; if (s_tx_ready !== 1'b1) $display("FAIL to_handshake got %b want 1", s_tx_ready); else passes++;
        @(posedge clock); #1;
        s_tx_valid = 1'b0;
        k = 0;
        while (nwr < n0 + 2 && k < 50) begin step(1); k++; end
        checks++; if (nwr - n0 != 2) $display("FAIL to_go_write got %0d writes want 2", nwr - n0); else passes++;
        step(15);
        checks++; if (tx_timeout !== 1'b0) $display("FAIL to_early got %b want 0", tx_timeout); else passes++;
        step(1);
        checks++; if (tx_timeout !== 1'b1) $display("FAIL to_flag got %b want 1", tx_timeout); else passes++;
        k = 0;
        while (nwr < n0 + 3 && k < 20) begin step(1); k++; end
        exp_wr.push_back({3'd1, 8'h5A});
        exp_wr.push_back({3'd0, 8'h15});
        exp_wr.push_back({3'd0, 8'h11});
        offer_tx(8'h5A, 1'b1, ok);
        step(2);
        checks++; if (ok !== 1'b1) $display("FAIL to_next_byte got %b want 1", ok); else passes++;
        checks++; if (tx_timeout !== 1'b1) $display("FAIL to_sticky got %b want 1", tx_timeout); else passes++;
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) $display("FAIL to_write got none want %h", e);
            else begin
                o = obs_wr.pop_front();
                if (o !== e) $display("FAIL to_write got %h want %h", o, e); else passes++;
            end
        end
        checks++; if (obs_wr.size() != 0) $display("FAIL to_extra_writes got %0d want 0", obs_wr.size()); else passes++;
        obs_wr.delete();
    endtask

    task automatic test_priority;
        bit ok;
        logic [10:0] e, o;
        logic [7:0] eb, ob;
`ifdef UART_REG_MASTER_STATS_EN
        logic [15:0] t0, r0;
        t0 = tx_count;
        r0 = rx_count;
`endif
        ev_q.delete();
        @(posedge clock); #1;
        m_rx_ready = 1'b1;
        exp_wr.push_back({3'd1, 8'hC3});
        exp_wr.push_back({3'd0, 8'h15});
        exp_wr.push_back({3'd0, 8'h11});
        exp_rx.push_back(8'h7E);
        rxd_m = 8'h7E;
        rx_valid_m = 1'b1;
        offer_tx(8'hC3, 1'b1, ok);
        rx_valid_m = 1'b0;
        step(5);
        checks++; if (ok !== 1'b1) $display("FAIL prio_tx got %b want 1", ok); else passes++;
        checks++; if (ev_q.size() != 2) $display("FAIL prio_events got %0d want 2", ev_q.size()); else passes++;
        if (ev_q.size() == 2) begin
            checks++; if (ev_q[0] !== 8'h52) $display("FAIL prio_first got %h want 52", ev_q[0]); else passes++;
            checks++; if (ev_q[1] !== 8'h54) $display("FAIL prio_second got %h want 54", ev_q[1]); else passes++;
        end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) $display("FAIL prio_write got none want %h", e);
            else begin
                o = obs_wr.pop_front();
                if (o !== e) $display("FAIL prio_write got %h want %h", o, e); else passes++;
            end
        end
        while (exp_rx.size() > 0) begin
            eb = exp_rx.pop_front();
            checks++;
            if (obs_rx.size() == 0) $display("FAIL prio_rx got none want %h", eb);
            else begin
                ob = obs_rx.pop_front();
                if (ob !== eb) $display("FAIL prio_rx got %h want %h", ob, eb); else passes++;
            end
        end
`ifdef UART_REG_MASTER_STATS_EN
        checks++; if (rx_count !== 16'(r0 + 16'd1)) $display("FAIL prio_rx_count got %0d want %0d", rx_count, r0 + 16'd1); else passes++;
        checks++; if (tx_count !== 16'(t0 + 16'd1)) $display("FAIL prio_tx_count got %0d want %0d", tx_count, t0 + 16'd1); else passes++;
`endif
    endtask

    initial begin
        test_reset;
        test_tx;
        test_rx_single;
        test_rx_overflow;
        test_timeout;
        test_priority;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
